// File: rtl/receiver.sv
// Receiver front-end of a switch node: arbitrates among the neighbour and
// local ports round-robin, copies the granted flit into the switch queue and
// acknowledges the sender.
//
// Handshake: a sender raises wr_ready_in[p] with its flit on data_i slice p.
// Once granted, mem_wr pulses for one cycle with the flit on mem_data, and
// r_ready_out[p] rises. r_ready_out[p] stays high until the sender drops
// wr_ready_in[p]. Only an exact 1 on wr_ready_in counts as a request.
module receiver #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 4,
    parameter int PORTS_NUM = 4
) (
    input  logic                                                  clk,
    input  logic                                                  a_rst_n,
    input  logic [PORTS_NUM:0]                                    wr_ready_in,
    input  logic [(DATA_SIZE+ADDR_SIZE+1)*(PORTS_NUM+1)-1:0]      data_i,
    input  logic                                                  mem_full,
    output logic [PORTS_NUM:0]                                    r_ready_out,
    output logic                                                  mem_wr,
    output logic [DATA_SIZE+ADDR_SIZE:0]                          mem_data,
    output logic [15:0]                                           rx_count
);

    localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;
    localparam int NP       = PORTS_NUM + 1;
    localparam int GW       = (NP > 1) ? $clog2(NP) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t              state;
    logic [GW-1:0]       grant;
    logic [GW-1:0]       last_grant;

    logic                found;
    logic [GW-1:0]       pick;
    logic [GW-1:0]       cand;
    logic [BUS_SIZE-1:0] pick_data;

    // Round-robin search starting one past the last served port, wrapping to 0.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= NP; i++) begin
            cand = GW'((int'(last_grant) + i) % NP);
            if (!found && (wr_ready_in[cand] == 1'b1)) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Flit slice of the port that would be granted this cycle.
    always_comb begin
        pick_data = '0;
        for (int p = 0; p < NP; p++) begin
            if (pick == GW'(p)) begin
                pick_data = data_i[p*BUS_SIZE +: BUS_SIZE];
            end
        end
    end

    // Transfer FSM; all outputs registered so they line up with the state.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            last_grant  <= GW'(PORTS_NUM);
            r_ready_out <= '0;
            mem_wr      <= 1'b0;
            mem_data    <= '0;
            rx_count    <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    mem_wr <= 1'b0;
                    if (!mem_full && found) begin
                        // Entering WRITE: strobe, acknowledge and count together.
                        grant       <= pick;
                        mem_data    <= pick_data;
                        mem_wr      <= 1'b1;
                        r_ready_out <= {{PORTS_NUM{1'b0}}, 1'b1} << pick;
                        rx_count    <= rx_count + 16'd1;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    // The write is already committed; mem_full is not consulted.
                    mem_wr <= 1'b0;
                    state  <= ACK;
                end
                ACK: begin
                    mem_wr <= 1'b0;
                    if (wr_ready_in[grant] == 1'b0) begin
                        r_ready_out <= '0;
                        last_grant  <= grant;
                        state       <= IDLE;
                    end
                end
                default: begin
                    mem_wr      <= 1'b0;
                    r_ready_out <= '0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_receiver.sv
// Directed bench for the receiver: one task per scenario, inline checks.
module tb_receiver;

    localparam int BUS = 37;
    localparam int NP  = 5;

    logic                clk;
    logic                a_rst_n;
    logic [NP-1:0]       wr_ready_in;
    logic [BUS*NP-1:0]   data_i;
    logic                mem_full;
    logic [NP-1:0]       r_ready_out;
    logic                mem_wr;
    logic [BUS-1:0]      mem_data;
    logic [15:0]         rx_count;

    int n_pass = 0;
    int n_total = 0;
    int wr_count = 0;
    int onehot_bad = 0;
    int cyc = 0;

    receiver dut (
        .clk         (clk),
        .a_rst_n     (a_rst_n),
        .wr_ready_in (wr_ready_in),
        .data_i      (data_i),
        .mem_full    (mem_full),
        .r_ready_out (r_ready_out),
        .mem_wr      (mem_wr),
        .mem_data    (mem_data),
        .rx_count    (rx_count)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: count write strobes and watch acknowledge exclusivity
    always @(negedge clk) begin
        if (mem_wr === 1'b1) wr_count <= wr_count + 1;
        if ($countones(r_ready_out) > 1) onehot_bad <= onehot_bad + 1;
    end

    task automatic do_reset();
        a_rst_n     = 1'b0;
        wr_ready_in = '0;
        mem_full    = 1'b0;
        data_i      = '0;
        repeat (2) @(negedge clk);
        a_rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits (bounded) for a negedge sample with mem_wr high.
    task automatic wait_write(input int limit, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit && !ok; c++) begin
            @(negedge clk);
            if (mem_wr === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        #3;
        n_total++;
        if (r_ready_out !== 5'b00000) $display("FAIL reset_r_ready got %b want 00000", r_ready_out);
        else n_pass++;
        n_total++;
        if (mem_wr !== 1'b0) $display("FAIL reset_mem_wr got %b want 0", mem_wr);
        else n_pass++;
        n_total++;
        if (mem_data !== 37'h0) $display("FAIL reset_mem_data got %h want 0", mem_data);
        else n_pass++;
        n_total++;
        if (rx_count !== 16'h0) $display("FAIL reset_rx_count got %h want 0", rx_count);
        else n_pass++;
    endtask

    task automatic test_single();
        bit ok;
        int base;
        do_reset();
        base = wr_count;
        data_i[0*BUS +: BUS] = 37'h0_1111_1111_1;
        data_i[1*BUS +: BUS] = 37'h0_2222_2222_2;
        data_i[2*BUS +: BUS] = 37'h1_DEAD_BEEF_3;
        data_i[3*BUS +: BUS] = 37'h0_4444_4444_4;
        wr_ready_in = 5'b00100;
        wait_write(10, ok);
        n_total++;
        if (!ok) $display("FAIL single_write_timeout got none want mem_wr");
        else n_pass++;
        n_total++;
        if (r_ready_out !== 5'b00100) $display("FAIL single_ack got %b want 00100", r_ready_out);
        else n_pass++;
        n_total++;
        if (mem_data !== 37'h1_DEAD_BEEF_3) $display("FAIL single_data got %h want 1deadbeef3", mem_data);
        else n_pass++;
        n_total++;
        if (rx_count !== 16'd1) $display("FAIL single_count got %0d want 1", rx_count);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (mem_wr !== 1'b0) $display("FAIL single_pulse_width got %b want 0", mem_wr);
        else n_pass++;
        n_total++;
        if (r_ready_out !== 5'b00100) $display("FAIL single_ack_hold got %b want 00100", r_ready_out);
        else n_pass++;
        wr_ready_in[2] = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if (r_ready_out !== 5'b00000) $display("FAIL single_ack_clear got %b want 00000", r_ready_out);
        else n_pass++;
        n_total++;
        if (wr_count - base !== 1) $display("FAIL single_nwrites got %0d want 1", wr_count - base);
        else n_pass++;
        n_total++;
        if (mem_data !== 37'h1_DEAD_BEEF_3) $display("FAIL single_data_hold got %h want 1deadbeef3", mem_data);
        else n_pass++;
    endtask

    task automatic test_contention();
        bit ok;
        int base;
        int t_first;
        int t_last;
        logic [BUS-1:0] exp_d;
        logic [NP-1:0] exp_g;
        do_reset();
        base = wr_count;
        t_first = 0;
        t_last = 0;
        for (int k = 0; k < NP; k++) data_i[k*BUS +: BUS] = 37'h1_0000_0000_0 + 37'(k * 37'h101);
        wr_ready_in = 5'b11111;
        for (int k = 0; k < NP; k++) begin
            wait_write(10, ok);
            if (k == 0) t_first = cyc;
            t_last = cyc;
            exp_g = 5'b00001 << k;
            exp_d = 37'h1_0000_0000_0 + 37'(k * 37'h101);
            n_total++;
            if (!ok || r_ready_out !== exp_g) $display("FAIL contention_grant%0d got %b want %b", k, r_ready_out, exp_g);
            else n_pass++;
            n_total++;
            if (mem_data !== exp_d) $display("FAIL contention_data%0d got %h want %h", k, mem_data, exp_d);
            else n_pass++;
            // Sender drops as soon as it sees its acknowledge.
            wr_ready_in = wr_ready_in & ~r_ready_out;
        end
        repeat (3) @(negedge clk);
        n_total++;
        if (wr_count - base !== 5) $display("FAIL contention_nwrites got %0d want 5", wr_count - base);
        else n_pass++;
        n_total++;
        if (rx_count !== 16'd5) $display("FAIL contention_count got %0d want 5", rx_count);
        else n_pass++;
        n_total++;
        if (t_last - t_first !== 12) $display("FAIL throughput_span got %0d want 12", t_last - t_first);
        else n_pass++;
        n_total++;
        if (r_ready_out !== 5'b00000) $display("FAIL contention_idle got %b want 00000", r_ready_out);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit ok;
        bit bad;
        do_reset();
        data_i[1*BUS +: BUS] = 37'h0_ABCD_0123_7;
        mem_full = 1'b1;
        wr_ready_in = 5'b00010;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mem_wr !== 1'b0 || r_ready_out !== 5'b00000) bad = 1'b1;
        end
        n_total++;
        if (bad) $display("FAIL backpressure_blocked got activity want none");
        else n_pass++;
        mem_full = 1'b0;
        wait_write(2, ok);
        n_total++;
        if (!ok) $display("FAIL backpressure_release got no write want write within 2");
        else n_pass++;
        n_total++;
        if (r_ready_out !== 5'b00010) $display("FAIL backpressure_ack got %b want 00010", r_ready_out);
        else n_pass++;
        n_total++;
        if (mem_data !== 37'h0_ABCD_0123_7) $display("FAIL backpressure_data got %h want 0abcd01237", mem_data);
        else n_pass++;
        wr_ready_in = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_slow_sender();
        bit ok;
        bit bad;
        int base;
        do_reset();
        base = wr_count;
        data_i[4*BUS +: BUS] = 37'h1_5555_AAAA_C;
        wr_ready_in = 5'b10000;
        wait_write(10, ok);
        n_total++;
        if (!ok) $display("FAIL slow_write_timeout got none want mem_wr");
        else n_pass++;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (r_ready_out !== 5'b10000 || mem_wr !== 1'b0) bad = 1'b1;
        end
        n_total++;
        if (bad) $display("FAIL slow_hold got early change want ack held");
        else n_pass++;
        wr_ready_in = '0;
        repeat (2) @(negedge clk);
        n_total++;
        if (r_ready_out !== 5'b00000) $display("FAIL slow_clear got %b want 00000", r_ready_out);
        else n_pass++;
        n_total++;
        if (wr_count - base !== 1) $display("FAIL slow_nwrites got %0d want 1", wr_count - base);
        else n_pass++;
    endtask

    task automatic test_reset_in_ack();
        bit ok;
        bit bad;
        do_reset();
        data_i[0*BUS +: BUS] = 37'h0_0F0F_0F0F_1;
        data_i[3*BUS +: BUS] = 37'h1_3333_4444_5;
        wr_ready_in = 5'b00001;
        wait_write(10, ok);
        @(negedge clk);
        n_total++;
        if (!ok || r_ready_out !== 5'b00001) $display("FAIL rstack_pre got %b want 00001", r_ready_out);
        else n_pass++;
        #2 a_rst_n = 1'b0;
        #1;
        n_total++;
        if (r_ready_out !== 5'b00000) $display("FAIL rstack_ready got %b want 00000", r_ready_out);
        else n_pass++;
        n_total++;
        if (rx_count !== 16'd0) $display("FAIL rstack_count got %0d want 0", rx_count);
        else n_pass++;
        n_total++;
        if (mem_data !== 37'h0) $display("FAIL rstack_data got %h want 0", mem_data);
        else n_pass++;
        wr_ready_in = '0;
        @(negedge clk);
        a_rst_n = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mem_wr !== 1'b0 || r_ready_out !== 5'b00000) bad = 1'b1;
        end
        n_total++;
        if (bad) $display("FAIL rstack_idle got activity want none");
        else n_pass++;
        wr_ready_in = 5'b01000;
        wait_write(10, ok);
        n_total++;
        if (!ok || r_ready_out !== 5'b01000) $display("FAIL rstack_reenter got %b want 01000", r_ready_out);
        else n_pass++;
        n_total++;
        if (rx_count !== 16'd1) $display("FAIL rstack_recount got %0d want 1", rx_count);
        else n_pass++;
        wr_ready_in = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_wrap_z();
        bit ok;
        bit bad;
        do_reset();
        data_i[0*BUS +: BUS] = 37'h0_7777_8888_9;
        data_i[3*BUS +: BUS] = 37'h1_FFFF_FFFF_F;
        force dut.rx_count = 16'hFFFF;
        @(negedge clk);
        release dut.rx_count;
        @(negedge clk);
        wr_ready_in = {1'b0, 1'bz, 3'b001};
        wait_write(10, ok);
        n_total++;
        if (!ok || r_ready_out !== 5'b00001) $display("FAIL wrap_grant got %b want 00001", r_ready_out);
        else n_pass++;
        n_total++;
        if (rx_count !== 16'd0) $display("FAIL wrap_count got %h want 0000", rx_count);
        else n_pass++;
        wr_ready_in[0] = 1'b0;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (r_ready_out[3] === 1'b1 || mem_wr === 1'b1) bad = 1'b1;
        end
        n_total++;
        if (bad) $display("FAIL z_request got grant want none");
        else n_pass++;
        n_total++;
        if (rx_count !== 16'd0) $display("FAIL z_count got %h want 0000", rx_count);
        else n_pass++;
        wr_ready_in = '0;
    endtask

    initial begin
        a_rst_n     = 1'b1;
        wr_ready_in = '0;
        mem_full    = 1'b0;
        data_i      = '0;
        #1 a_rst_n  = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_slow_sender();
        test_reset_in_ack();
        test_wrap_z();
        @(negedge clk);
        n_total++;
        if (onehot_bad !== 0) $display("FAIL onehot_ack got %0d violations want 0", onehot_bad);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
